// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews the pwm duty word toward a target once per PWM period (optional PWM_RAMP_PRESCALE_EN slows updates to every PRESCALE-th period).
module pwm_duty_ramp #(
  parameter int N = 9
`ifdef PWM_RAMP_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] target,
  input  logic         target_valid,
  input  logic [N-1:0] step,
  input  logic         hold,
  output logic [N-1:0] duty,
  output logic         period_tick,
  output logic         ramping,
  output logic         at_target
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t state, state_next;
  logic [N-1:0] cnt, tgt_reg, tgt_next, duty_next, up_val, dn_val;
  logic [N:0] sum, diff;
  logic upd;
  assign period_tick = &cnt;
  assign ramping = state != IDLE;
  assign at_target = state == IDLE;
`ifdef PWM_RAMP_PRESCALE_EN
  logic [7:0] psc;
  logic psc_last;
  assign psc_last = psc == 8'(PRESCALE - 1);
  always_ff @(posedge clk)
    if (reset) psc <= '0;
    else if (period_tick) psc <= psc_last ? '0 : psc + 8'd1;
  assign upd = period_tick && !hold && psc_last;
`else
  assign upd = period_tick && !hold;
`endif
  // N+1-bit sum/difference so overshoot past the target or the rails clamps instead of wrapping
  always_comb begin
    sum = {1'b0, duty} + {1'b0, step};
    diff = {1'b0, duty} - {1'b0, step};
    up_val = (sum >= {1'b0, tgt_reg}) ? tgt_reg : sum[N-1:0];
    dn_val = (diff[N] || diff <= {1'b0, tgt_reg}) ? tgt_reg : diff[N-1:0];
    tgt_next = target_valid ? target : tgt_reg;
    duty_next = !upd ? duty : (step == '0) ? tgt_reg : (duty < tgt_reg) ? up_val : (duty > tgt_reg) ? dn_val : duty;
    state_next = (duty_next < tgt_next) ? UP : (duty_next > tgt_next) ? DOWN : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      tgt_reg <= '0;
      duty <= '0;
      state <= IDLE;
    end else begin
      cnt <= cnt + 1'b1;
      tgt_reg <= tgt_next;
      duty <= duty_next;
      state <= state_next;
    end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed scoreboard bench; expected duty after each period tick is queued and checked by a monitor.
module tb_pwm_duty_ramp;
  typedef struct {int d; logic r;} exp_t;
  logic clk = 0, reset = 1, target_valid = 0, hold = 0;
  logic [8:0] target = '0, step = '0, duty;
  logic period_tick, ramping, at_target;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0, last_tick = -1;
  bit pending = 0;

  pwm_duty_ramp #(.N(9)) dut (
    .clk(clk), .reset(reset), .target(target), .target_valid(target_valid),
    .step(step), .hold(hold), .duty(duty), .period_tick(period_tick),
    .ramping(ramping), .at_target(at_target)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      pending = 0;
      cyc = 0;
      last_tick = -1;
    end else begin
      if (pending && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("tick_duty", int'(duty), e.d);
        chk("tick_ramping", int'(ramping), int'(e.r));
        chk("tick_at_target", int'(at_target), int'(!e.r));
      end
      pending = period_tick;
      if (period_tick) begin
        chk("tick_spacing", cyc, last_tick + 512);
        last_tick = cyc;
      end
      cyc++;
    end
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 600);
    if (!period_tick) begin
      errors++;
      checks++;
      $display("FAIL tick_timeout: no period_tick within %0d cycles", n);
    end
  endtask

  task automatic tick_exp(input int d, input logic r);
    wait_tick();
    q.push_back('{d, r});
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int t, input int s);
    target = 9'(t);
    step = 9'(s);
    target_valid = 1;
    @(posedge clk);
    #1;
    target_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_duty", int'(duty), 0);
    chk("reset_at_target", int'(at_target), 1);
    chk("reset_ramping", int'(ramping), 0);
    chk("reset_tick", int'(period_tick), 0);
    repeat (9) @(posedge clk);
    #1 strobe(100, 30);
    @(negedge clk);
    chk("strobe_no_duty_change", int'(duty), 0);
    chk("strobe_ramping", int'(ramping), 1);
    tick_exp(30, 1);
    tick_exp(60, 1);
    tick_exp(90, 1);
    tick_exp(100, 0);
    tick_exp(100, 0);
    strobe(0, 40);
    tick_exp(60, 1);
    tick_exp(20, 1);
    tick_exp(0, 0);
    strobe(500, 0);
    tick_exp(500, 0);
    strobe(511, 50);
    tick_exp(511, 0);
    strobe(300, 0);
    tick_exp(300, 0);
    strobe(250, 0);
    tick_exp(250, 0);
    strobe(300, 10);
    wait_tick();
    q.push_back('{260, 1'b1});
    target = 9'd50;
    target_valid = 1;
    @(posedge clk);
    #1 target_valid = 0;
    tick_exp(250, 1);
    hold = 1;
    tick_exp(250, 1);
    tick_exp(250, 1);
    hold = 0;
    tick_exp(240, 1);
    repeat (5) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midramp_reset_duty", int'(duty), 0);
    chk("midramp_reset_at_target", int'(at_target), 1);
    chk("midramp_reset_ramping", int'(ramping), 0);
    chk("midramp_reset_tick", int'(period_tick), 0);
    reset = 0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
